pcm_envelope_decim: RTL and testbench
=====================================

PCM_ENVELOPE_DECIM -- requirements
Module: pcm_envelope_decim

Interface
REQ-001 SHALL have parameter CHANNEL, default 3: number of independent PCM lanes.
REQ-002 SHALL have parameter MAX_SHIFT, default 8: largest log2 decimation factor.
REQ-003 SHALL have port pcm_clk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port en, input, 1: run enable, shared by all lanes.
REQ-006 SHALL have port cfg_load, input, 1: one-cycle pulse that latches dec_shift and clears accumulation.
REQ-007 SHALL have port dec_shift, input, 4: requested log2 decimation factor N.
REQ-008 SHALL have port pcm_in_valid, input, CHANNEL: per-lane input valid (FIR output).
REQ-009 SHALL have port pcm_in_ready, output, CHANNEL: per-lane input ready.
REQ-010 SHALL have port pcm_in, input, 16*CHANNEL: signed two's-complement samples, lane c at bits [16c+15:16c].
REQ-011 SHALL have port pcm_out_valid, output, CHANNEL: per-lane envelope valid.
REQ-012 SHALL have port pcm_out_ready, input, CHANNEL: per-lane downstream ready.
REQ-013 SHALL have port pcm_out, output, 16*CHANNEL: unsigned envelope, same lane packing.

Function
REQ-014 SHALL latch shift_q = min(dec_shift, MAX_SHIFT) on a cycle with cfg_load=1; shift_q SHALL be 0 after reset.
REQ-015 SHALL accept a sample on lane c only when pcm_in_valid[c] and pcm_in_ready[c] are both 1.
REQ-016 SHALL drive pcm_in_ready[c] = en and not cfg_load and (not pcm_out_valid[c] or pcm_out_ready[c]).
REQ-017 SHALL compute the magnitude of each accepted sample as |x|, with -32768 saturated to 32767 (15-bit result).
REQ-018 SHALL keep a per-lane accumulator of width 15+MAX_SHIFT bits and a per-lane sample counter of width MAX_SHIFT bits.
REQ-019 On each accepted sample whose counter value is below 2^shift_q-1, the block SHALL add |x| to the accumulator and increment the counter.
REQ-020 On the accepted sample whose counter value equals 2^shift_q-1, the block SHALL load (acc+|x|)>>shift_q into the output register, truncating with no rounding, and SHALL clear the accumulator and counter.
REQ-021 SHALL drive the output register with MSB always 0; the maximum output value is 32767.
REQ-022 SHALL have a latency of 1 cycle: pcm_out_valid[c] rises on the edge that accepts the final sample of a group.
REQ-023 SHALL hold pcm_out[c] and pcm_out_valid[c] stable while pcm_out_valid[c]=1 and pcm_out_ready[c]=0.
REQ-024 SHALL clear pcm_out_valid[c] on a cycle where valid and ready are both 1 and no new result is produced.
REQ-025 When a result drains and a new result is produced in the same cycle, the output SHALL load the new value with valid remaining 1.
REQ-026 SHALL clear the accumulator and counter of every lane on a cycle with cfg_load=1 or en=0; pending outputs are not cleared and SHALL still drain.
REQ-027 On a cycle where cfg_load=1 coincides with pcm_in_valid=1, the sample SHALL NOT be accepted, because ready is 0 (REQ-016).
REQ-028 When shift_q=0, every accepted sample SHALL produce an output, acting as an abs pass-through.
REQ-029 SHALL operate all lanes independently, with no cross-lane stalls.

Reset
REQ-030 While rst_n=0, the block SHALL immediately drive pcm_out_valid=0, pcm_out=0, accumulators=0, counters=0 and shift_q=0, independent of pcm_clk.
REQ-031 SHALL drive pcm_in_ready from combinational logic; it SHALL equal en and not cfg_load during and after reset.
REQ-032 Reset asserted mid-group SHALL discard partial sums; the first group after release SHALL start at counter 0.

Verification
REQ-033 Basic: en=1, cfg_load with dec_shift=2, then lane 0 receives 100,-200,300,-400 back-to-back with ready=1 -> one pcm_out_valid pulse, value 250, 1 cycle after the 4th sample.
REQ-034 Saturation: dec_shift=2, four samples of -32768 -> output 32767; dec_shift=0, sample -5 -> output 5 on the next cycle.
REQ-035 Backpressure: dec_shift=1, pcm_out_ready=0 after the first result (value 15 from 10,20) -> pcm_in_ready=0, output held at 15; release ready -> 15 consumed, input resumes, no sample lost.
REQ-036 Reconfigure mid-group: dec_shift=2, accept 1000,1000, then cfg_load with dec_shift=1 and pcm_in_valid=1 in the same cycle -> that sample is not accepted; next 10,20 -> output 15.
REQ-037 Clamp and lane independence: dec_shift=15 -> shift_q=8, 256 samples of 7 on lane 1 -> output 7; lanes 0 and 2 are idle with valid=0 throughout.
REQ-038 Async reset: rst_n pulsed low mid-group and mid-stall -> pcm_out_valid=0 without a clock edge; after release with dec_shift=0 (shift_q=0), first sample 3 -> output 3.

Source files
------------

// File: rtl/pcm_envelope_decim.sv
// pcm_envelope_decim: per-lane PCM envelope detector and power-of-two
// decimator. Each lane averages |x| over 2^shift_q accepted samples and
// presents the truncated mean on a valid/ready output register.
module pcm_envelope_decim #(
  parameter int CHANNEL   = 3,
  parameter int MAX_SHIFT = 8
) (
  input  logic                    pcm_clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    cfg_load,
  input  logic [3:0]              dec_shift,
  input  logic [CHANNEL-1:0]      pcm_in_valid,
  output logic [CHANNEL-1:0]      pcm_in_ready,
  input  logic [16*CHANNEL-1:0]   pcm_in,
  output logic [CHANNEL-1:0]      pcm_out_valid,
  input  logic [CHANNEL-1:0]      pcm_out_ready,
  output logic [16*CHANNEL-1:0]   pcm_out
);

  // Accumulator holds up to 2^MAX_SHIFT magnitudes of 15 bits without overflow.
  localparam int         ACC_W       = 15 + MAX_SHIFT;
  localparam logic [3:0] MAX_SHIFT_C = 4'(MAX_SHIFT);

  logic [3:0]           shift_q;
  logic [3:0]           shift_d;
  logic [MAX_SHIFT:0]   group_pow;
  logic [MAX_SHIFT-1:0] group_last;
  logic                 clear_acc;

  // Clamp the requested decimation on cfg_load and derive the last-sample count.
  always_comb begin
    shift_d = shift_q;
    if (cfg_load) begin
      shift_d = (dec_shift > MAX_SHIFT_C) ? MAX_SHIFT_C : dec_shift;
    end
    group_pow  = {{MAX_SHIFT{1'b0}}, 1'b1} << shift_q;
    group_last = MAX_SHIFT'(group_pow - 1'b1);
    clear_acc  = cfg_load | ~en;
  end

  // Decimation setting register.
  always_ff @(posedge pcm_clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= 4'd0;
    end else begin
      shift_q <= shift_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNEL; gi++) begin : g_lane
      logic signed [15:0]   x;
      logic [14:0]          mag;
      logic [ACC_W-1:0]     sum;
      logic [ACC_W-1:0]     acc_q, acc_d;
      logic [MAX_SHIFT-1:0] cnt_q, cnt_d;
      logic [15:0]          out_q, out_d;
      logic                 ov_q, ov_d;
      logic                 accept;

      // Ready is combinational so it tracks en/cfg_load even while in reset.
      assign pcm_in_ready[gi]          = en & ~cfg_load & (~ov_q | pcm_out_ready[gi]);
      assign pcm_out_valid[gi]         = ov_q;
      assign pcm_out[16*gi +: 16]      = out_q;

      // Magnitude, accumulation and output-register update for this lane.
      always_comb begin
        x      = pcm_in[16*gi +: 16];
        accept = pcm_in_valid[gi] & pcm_in_ready[gi];
        if (x == 16'sh8000) begin
          mag = 15'h7fff;
        end else if (x[15]) begin
          mag = 15'(~x[14:0]) + 15'd1;
        end else begin
          mag = x[14:0];
        end
        sum   = acc_q + ACC_W'(mag);
        acc_d = acc_q;
        cnt_d = cnt_q;
        out_d = out_q;
        ov_d  = ov_q;
        if (ov_q && pcm_out_ready[gi]) begin
          ov_d = 1'b0;
        end
        if (clear_acc) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (accept) begin
          if (cnt_q == group_last) begin
            // Mean of the group is < 2^15, so the top output bit is always 0.
            out_d = 16'(sum >> shift_q) & 16'h7fff;
            ov_d  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + MAX_SHIFT'(1);
          end
        end
      end

      // Lane state; reset discards any partial group and pending output.
      always_ff @(posedge pcm_clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q <= '0;
          cnt_q <= '0;
          out_q <= '0;
          ov_q  <= 1'b0;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          out_q <= out_d;
          ov_q  <= ov_d;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pcm_envelope_decim.sv
// Directed testbench for pcm_envelope_decim with hand-computed expectations.
module tb_pcm_envelope_decim;

  localparam int CH = 3;

  logic              pcm_clk;
  logic              rst_n;
  logic              en;
  logic              cfg_load;
  logic [3:0]        dec_shift;
  logic [CH-1:0]     pcm_in_valid;
  logic [CH-1:0]     pcm_in_ready;
  logic [16*CH-1:0]  pcm_in;
  logic [CH-1:0]     pcm_out_valid;
  logic [CH-1:0]     pcm_out_ready;
  logic [16*CH-1:0]  pcm_out;

  int checks;
  int errors;

  pcm_envelope_decim #(.CHANNEL(CH), .MAX_SHIFT(8)) dut (
    .pcm_clk       (pcm_clk),
    .rst_n         (rst_n),
    .en            (en),
    .cfg_load      (cfg_load),
    .dec_shift     (dec_shift),
    .pcm_in_valid  (pcm_in_valid),
    .pcm_in_ready  (pcm_in_ready),
    .pcm_in        (pcm_in),
    .pcm_out_valid (pcm_out_valid),
    .pcm_out_ready (pcm_out_ready),
    .pcm_out       (pcm_out)
  );

  initial pcm_clk = 1'b0;
  always #5 pcm_clk = ~pcm_clk;

  task automatic tick();
    @(posedge pcm_clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] sh);
    cfg_load  = 1'b1;
    dec_shift = sh;
    tick();
    cfg_load  = 1'b0;
  endtask

  task automatic send(input int lane, input logic [15:0] val);
    pcm_in_valid[lane]     = 1'b1;
    pcm_in[16*lane +: 16]  = val;
    tick();
    pcm_in_valid[lane]     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; cfg_load = 1'b0; dec_shift = 4'd0;
    pcm_in_valid = '0; pcm_in = '0; pcm_out_ready = '1;
    #2;
    checks++;
    if (pcm_out_valid !== 3'b000 || pcm_out !== 48'd0) begin
      errors++;
      $display("FAIL reset_out valid=%b out=%h expected valid=000 out=0", pcm_out_valid, pcm_out);
    end
    checks++;
    if (pcm_in_ready !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready_en0 got=%b expected=000", pcm_in_ready);
    end
    en = 1'b1; #1;
    checks++;
    if (pcm_in_ready !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready_en1 got=%b expected=111", pcm_in_ready);
    end
    cfg_load = 1'b1; #1;
    checks++;
    if (pcm_in_ready !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready_cfg got=%b expected=000", pcm_in_ready);
    end
    cfg_load = 1'b0;
    #17 rst_n = 1'b1;
    tick();
    checks++;
    if (pcm_out_valid !== 3'b000 || pcm_out !== 48'd0) begin
      errors++;
      $display("FAIL post_reset_out valid=%b out=%h expected valid=000 out=0", pcm_out_valid, pcm_out);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    cfg(4'd2);
    send(0, 16'd100);
    send(0, -16'sd200);
    send(0, 16'd300);
    checks++;
    if (pcm_out_valid !== 3'b000) begin
      errors++;
      $display("FAIL basic_early_valid got=%b expected=000", pcm_out_valid);
    end
    send(0, -16'sd400);
    checks++;
    if (pcm_out_valid !== 3'b001 || pcm_out[15:0] !== 16'd250) begin
      errors++;
      $display("FAIL basic_result valid=%b out=%0d expected valid=001 out=250", pcm_out_valid, pcm_out[15:0]);
    end
    tick();
    checks++;
    if (pcm_out_valid !== 3'b000) begin
      errors++;
      $display("FAIL basic_drain got=%b expected=000", pcm_out_valid);
    end
    $display("test_basic done out=250");
  endtask

  task automatic test_saturation();
    cfg(4'd2);
    for (int i = 0; i < 4; i++) send(0, 16'h8000);
    checks++;
    if (pcm_out_valid[0] !== 1'b1 || pcm_out[15:0] !== 16'd32767) begin
      errors++;
      $display("FAIL sat_max valid=%b out=%0d expected valid=1 out=32767", pcm_out_valid[0], pcm_out[15:0]);
    end
    cfg(4'd0);
    send(0, -16'sd5);
    checks++;
    if (pcm_out_valid[0] !== 1'b1 || pcm_out[15:0] !== 16'd5) begin
      errors++;
      $display("FAIL sat_passthru valid=%b out=%0d expected valid=1 out=5", pcm_out_valid[0], pcm_out[15:0]);
    end
    $display("test_saturation done");
  endtask

  task automatic test_backpressure();
    cfg(4'd1);
    send(0, 16'd10);
    send(0, 16'd20);
    checks++;
    if (pcm_out_valid[0] !== 1'b1 || pcm_out[15:0] !== 16'd15) begin
      errors++;
      $display("FAIL bp_first valid=%b out=%0d expected valid=1 out=15", pcm_out_valid[0], pcm_out[15:0]);
    end
    pcm_out_ready[0] = 1'b0;
    #1;
    checks++;
    if (pcm_in_ready !== 3'b110) begin
      errors++;
      $display("FAIL bp_ready got=%b expected=110", pcm_in_ready);
    end
    pcm_in_valid[0] = 1'b1;
    pcm_in[15:0]    = 16'd30;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (pcm_out_valid[0] !== 1'b1 || pcm_out[15:0] !== 16'd15) begin
      errors++;
      $display("FAIL bp_hold valid=%b out=%0d expected valid=1 out=15", pcm_out_valid[0], pcm_out[15:0]);
    end
    pcm_out_ready[0] = 1'b1;
    tick();
    pcm_in_valid[0] = 1'b0;
    checks++;
    if (pcm_out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_consume valid=%b expected=0", pcm_out_valid[0]);
    end
    send(0, 16'd40);
    checks++;
    if (pcm_out_valid[0] !== 1'b1 || pcm_out[15:0] !== 16'd35) begin
      errors++;
      $display("FAIL bp_resume valid=%b out=%0d expected valid=1 out=35", pcm_out_valid[0], pcm_out[15:0]);
    end
    tick();
    $display("test_backpressure done");
  endtask

  task automatic test_reconfig();
    cfg(4'd2);
    send(0, 16'd1000);
    send(0, 16'd1000);
    cfg_load        = 1'b1;
    dec_shift       = 4'd1;
    pcm_in_valid[0] = 1'b1;
    pcm_in[15:0]    = 16'd5000;
    #1;
    checks++;
    if (pcm_in_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL reconfig_ready got=%b expected=0", pcm_in_ready[0]);
    end
    tick();
    cfg_load        = 1'b0;
    pcm_in_valid[0] = 1'b0;
    send(0, 16'd10);
    checks++;
    if (pcm_out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL reconfig_early valid=%b expected=0", pcm_out_valid[0]);
    end
    send(0, 16'd20);
    checks++;
    if (pcm_out_valid[0] !== 1'b1 || pcm_out[15:0] !== 16'd15) begin
      errors++;
      $display("FAIL reconfig_result valid=%b out=%0d expected valid=1 out=15", pcm_out_valid[0], pcm_out[15:0]);
    end
    tick();
    $display("test_reconfig done");
  endtask

  task automatic test_clamp();
    int early;
    early = 0;
    cfg(4'd15);
    pcm_in_valid[1] = 1'b1;
    pcm_in[31:16]   = 16'd7;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (pcm_out_valid !== 3'b000) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL clamp_early count=%0d expected=0", early);
    end
    tick();
    pcm_in_valid[1] = 1'b0;
    checks++;
    if (pcm_out_valid !== 3'b010 || pcm_out[31:16] !== 16'd7) begin
      errors++;
      $display("FAIL clamp_result valid=%b out=%0d expected valid=010 out=7", pcm_out_valid, pcm_out[31:16]);
    end
    tick();
    $display("test_clamp done");
  endtask

  task automatic test_async_reset();
    cfg(4'd1);
    send(2, 16'd9);
    send(0, 16'd10);
    send(0, 16'd20);
    pcm_out_ready[0] = 1'b0;
    tick();
    checks++;
    if (pcm_out_valid[0] !== 1'b1 || pcm_out[15:0] !== 16'd15) begin
      errors++;
      $display("FAIL areset_stall valid=%b out=%0d expected valid=1 out=15", pcm_out_valid[0], pcm_out[15:0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pcm_out_valid !== 3'b000 || pcm_out !== 48'd0) begin
      errors++;
      $display("FAIL areset_immediate valid=%b out=%h expected valid=000 out=0", pcm_out_valid, pcm_out);
    end
    pcm_out_ready = '1;
    dec_shift     = 4'd0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    send(2, 16'd3);
    checks++;
    if (pcm_out_valid !== 3'b100 || pcm_out[47:32] !== 16'd3) begin
      errors++;
      $display("FAIL areset_first valid=%b out=%0d expected valid=100 out=3", pcm_out_valid, pcm_out[47:32]);
    end
    tick();
    $display("test_async_reset done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_reconfig();
    test_clamp();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
